// File: rtl/fault_decoder_pkg.sv
// Shared definitions for the fault decoder: cause codes, register map,
// STATUS bit positions, sequencer states and the cause-to-class decode.
package fault_decoder_pkg;

  localparam int XLEN = 32;

  localparam logic [7:0] RST_FAULT_CORE = 8'h01;
  localparam logic [7:0] RST_FAULT_IBUS = 8'h02;
  localparam logic [7:0] RST_FAULT_DBUS = 8'h03;
  localparam logic [7:0] RST_FAULT_IPER = 8'h04;
  localparam logic [7:0] RST_FAULT_DPER = 8'h05;

  localparam logic [3:0] FAULT_STATUS = 4'h0;
  localparam logic [3:0] FAULT_CAUSE  = 4'h4;
  localparam logic [3:0] FAULT_ADDR   = 4'h8;
  localparam logic [3:0] FAULT_COUNT  = 4'hC;

  localparam int NUM_FLAGS     = 6;
  localparam int FLAG_CORE     = 0;
  localparam int FLAG_IBUS     = 1;
  localparam int FLAG_DBUS     = 2;
  localparam int FLAG_IPER     = 3;
  localparam int FLAG_DPER     = 4;
  localparam int FLAG_UNKNOWN  = 5;
  localparam int STATUS_OVF    = 8;
  localparam int STATUS_VALID  = 31;
  localparam int COUNT_RST_REQ = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_REQ  = 2'd2
  } fsm_state_t;

  // One-hot class flag for a cause code; unrecognised codes land in UNKNOWN.
  function automatic logic [NUM_FLAGS-1:0] decode_cause(input logic [7:0] cause);
    logic [NUM_FLAGS-1:0] f;
    f = '0;
    case (cause)
      RST_FAULT_CORE: f[FLAG_CORE]    = 1'b1;
      RST_FAULT_IBUS: f[FLAG_IBUS]    = 1'b1;
      RST_FAULT_DBUS: f[FLAG_DBUS]    = 1'b1;
      RST_FAULT_IPER: f[FLAG_IPER]    = 1'b1;
      RST_FAULT_DPER: f[FLAG_DPER]    = 1'b1;
      default:        f[FLAG_UNKNOWN] = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fault_edge_detect.sv
// New-fault-event detector: keeps the previous sample of the upstream
// fault record and flags a rising fault level or any change of the record
// while the fault level is high.
module fault_edge_detect
  import fault_decoder_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            fault,
  input  logic [7:0]      fault_cause,
  input  logic [XLEN-1:0] fault_addr,
  output logic            evt
);

  logic                 fault_q;
  logic [8+XLEN-1:0]    prev_q;

  // Sample the record every cycle so each distinct record counts once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fault_q <= 1'b0;
      prev_q  <= '0;
    end else begin
      fault_q <= fault;
      prev_q  <= {fault_cause, fault_addr};
    end
  end

  assign evt = fault & (~fault_q | ({fault_cause, fault_addr} != prev_q));

endmodule

// File: rtl/fault_decoder.sv
// Fault record decoder: sticky class flags, first-fault snapshot, saturating
// event counter, word registers on the peripheral bus, and an optional
// delayed system reset request (build with FAULT_AUTO_RESET_EN).
module fault_decoder
  import fault_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            fault,
  input  logic [7:0]      fault_cause,
  input  logic [XLEN-1:0] fault_addr,
  input  logic            req,
  input  logic            we,
  input  logic [3:0]      addr,
  input  logic [XLEN-1:0] wdata,
  output logic            rvld,
  output logic [XLEN-1:0] rdata,
  output logic            bus_fault,
  output logic            sys_rst_req,
  input  logic            rst_ack
);

  logic                 evt;
  logic                 clr;
  logic                 rd_ok;
  logic                 misal;
  logic                 valid_q;
  logic                 ovf_q;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] dec;
  logic [7:0]           cause_q;
  logic [XLEN-1:0]      addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [XLEN-1:0]      rd_mux;
  logic                 unused_wdata;

  fault_edge_detect u_edge (
    .clk         (clk),
    .rstn        (rstn),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr),
    .evt         (evt)
  );

  assign misal = req & (addr[1:0] != 2'b00);
  assign rd_ok = req & ~we & (addr[1:0] == 2'b00);
  assign clr   = req & we & (addr == FAULT_STATUS) & wdata[STATUS_VALID];
  assign dec   = decode_cause(fault_cause);
  assign unused_wdata = &{1'b0, wdata[STATUS_VALID-1:0]};

  // Record update; an event coincident with a clear starts a fresh record.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      flags_q <= '0;
      cause_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else if (evt) begin
      if (!valid_q || clr) begin
        valid_q <= 1'b1;
        ovf_q   <= 1'b0;
        flags_q <= dec;
        cause_q <= fault_cause;
        addr_q  <= fault_addr;
        cnt_q   <= CNT_W'(1);
      end else begin
        ovf_q   <= 1'b1;
        flags_q <= flags_q | dec;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
    end else if (clr) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      flags_q <= '0;
      cnt_q   <= '0;
    end
  end

  // Register read mux.
  always_comb begin
    rd_mux = '0;
    case (addr)
      FAULT_STATUS: begin
        rd_mux[NUM_FLAGS-1:0] = flags_q;
        rd_mux[STATUS_OVF]    = ovf_q;
        rd_mux[STATUS_VALID]  = valid_q;
      end
      FAULT_CAUSE: rd_mux[7:0] = cause_q;
      FAULT_ADDR:  rd_mux      = addr_q;
      FAULT_COUNT: begin
        rd_mux[CNT_W-1:0]    = cnt_q;
        rd_mux[COUNT_RST_REQ] = sys_rst_req;
      end
      default: rd_mux = '0;
    endcase
  end

  // Bus response: read data one cycle after an aligned read, fault pulse on misalignment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvld      <= 1'b0;
      rdata     <= '0;
      bus_fault <= 1'b0;
    end else begin
      rvld      <= rd_ok;
      rdata     <= rd_ok ? rd_mux : '0;
      bus_fault <= misal;
    end
  end

`ifdef FAULT_AUTO_RESET_EN
  fsm_state_t  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        rst_req_q;

  // Sequencer state, hold timer and registered reset request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      rst_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rst_req_q <= (state_d == ST_REQ);
    end
  end

  // Next state: hold after the first event, then request until acknowledged.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          state_d = ST_HOLD;
          timer_d = 16'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (clr && !evt)          state_d = ST_IDLE;
        else if (timer_q == 16'd0) state_d = ST_REQ;
        else                      timer_d = timer_q - 16'd1;
      end
      ST_REQ: begin
        if (rst_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sys_rst_req = rst_req_q;
`else
  logic unused_ack;
  assign unused_ack  = rst_ack;
  assign sys_rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_fault_decoder.sv
// Self-checking bench for fault_decoder: scoreboarded register reads against
// a behavioural record model, plus reset-sequencer timing checks.
module tb_fault_decoder;
  import fault_decoder_pkg::*;

  localparam int HOLD = 16;
  localparam int CW   = 8;
`ifdef FAULT_AUTO_RESET_EN
  localparam logic [31:0] REQ_BIT = 32'h0001_0000;
`else
  localparam logic [31:0] REQ_BIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fault = 1'b0;
  logic [7:0]  fault_cause = 8'h00;
  logic [31:0] fault_addr = 32'h0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        rvld;
  logic [31:0] rdata;
  logic        bus_fault;
  logic        sys_rst_req;
  logic        rst_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Behavioural model of the record and the previous input sample
  logic        m_valid = 1'b0;
  logic        m_ovf = 1'b0;
  logic [5:0]  m_flags = 6'h0;
  logic [7:0]  m_cause = 8'h0;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;
  logic        p_fault = 1'b0;
  logic [7:0]  p_cause = 8'h0;
  logic [31:0] p_addr = 32'h0;

  fault_decoder #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rvld        (rvld),
    .rdata       (rdata),
    .bus_fault   (bus_fault),
    .sys_rst_req (sys_rst_req),
    .rst_ack     (rst_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_flags(input logic [7:0] c);
    case (c)
      8'h01:   return 6'b000001;
      8'h02:   return 6'b000010;
      8'h03:   return 6'b000100;
      8'h04:   return 6'b001000;
      8'h05:   return 6'b010000;
      default: return 6'b100000;
    endcase
  endfunction

  function automatic logic [31:0] exp_status();
    return {m_valid, 22'b0, m_ovf, 2'b0, m_flags};
  endfunction

  // Aligned read: expectation is queued at request time, checked when rvld returns
  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    logic [31:0] want;
    exp_q.push_back(e);
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    req = 1'b0;
    total++;
    want = exp_q.pop_front();
    if (rvld !== 1'b1) begin
      bad++;
      $display("FAIL %s: rvld=%b required 1", nm, rvld);
    end else if (rdata !== want) begin
      bad++;
      $display("FAIL %s: rdata=%h required %h", nm, rdata, want);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; wdata = 32'h0;
  endtask

  // Drive one cycle of upstream record (optionally with a STATUS clear) and step the model
  task automatic drive_rec(input logic f, input logic [7:0] c, input logic [31:0] a, input logic do_clr);
    logic ev;
    fault = f; fault_cause = c; fault_addr = a;
    if (do_clr) begin
      req = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h8000_0000;
    end
    ev = f && (!p_fault || c != p_cause || a != p_addr);
    if (ev) begin
      if (!m_valid || do_clr) begin
        m_valid = 1'b1; m_ovf = 1'b0; m_flags = ref_flags(c);
        m_cause = c; m_addr = a; m_cnt = 1;
      end else begin
        m_flags = m_flags | ref_flags(c);
        m_ovf = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end else if (do_clr) begin
      m_valid = 1'b0; m_ovf = 1'b0; m_flags = 6'h0; m_cnt = 0;
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; wdata = 32'h0;
    p_fault = f; p_cause = c; p_addr = a;
  endtask

  task automatic ack_pulse();
    rst_ack = 1'b1;
    @(posedge clk); #1;
    rst_ack = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (sys_rst_req !== 1'b0) begin
      bad++; $display("FAIL reset_rst_req: got %b required 0", sys_rst_req);
    end
    rd(FAULT_STATUS, 32'h0, "reset_status");
    rd(FAULT_CAUSE,  32'h0, "reset_cause");
    rd(FAULT_ADDR,   32'h0, "reset_addr");
    rd(FAULT_COUNT,  32'h0, "reset_count");
  endtask

  task automatic test_first_fault();
    int n;
    drive_rec(1'b1, RST_FAULT_DBUS, 32'h2000_0010, 1'b0);
    n = 1;
    while (sys_rst_req !== 1'b1 && n < HOLD + 8) begin
      @(posedge clk); #1; n++;
    end
    total++;
`ifdef FAULT_AUTO_RESET_EN
    if (n !== HOLD + 1) begin
      bad++; $display("FAIL hold_delay: rose after %0d cycles required %0d", n, HOLD + 1);
    end
`else
    if (sys_rst_req !== 1'b0) begin
      bad++; $display("FAIL no_auto_rst_req: got %b required 0", sys_rst_req);
    end
`endif
    rd(FAULT_STATUS, 32'h8000_0004, "first_status");
    rd(FAULT_CAUSE,  32'h0000_0003, "first_cause");
    rd(FAULT_ADDR,   32'h2000_0010, "first_addr");
    rd(FAULT_COUNT,  32'h1 | REQ_BIT, "first_count");
    ack_pulse();
    total++;
    if (sys_rst_req !== 1'b0) begin
      bad++; $display("FAIL ack_release: sys_rst_req=%b required 0", sys_rst_req);
    end
  endtask

  task automatic test_second_event();
    drive_rec(1'b1, RST_FAULT_CORE, 32'h2000_0014, 1'b0);
    rd(FAULT_ADDR,   32'h2000_0010, "second_addr");
    rd(FAULT_STATUS, 32'h8000_0105, "second_status");
    rd(FAULT_COUNT,  32'h2, "second_count");
  endtask

  task automatic test_clear_hold();
    bit seen;
    drive_rec(1'b1, RST_FAULT_CORE, 32'h2000_0014, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < HOLD + 5; i++) begin
      @(posedge clk); #1;
      if (sys_rst_req === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL clear_abort: sys_rst_req seen=1 required 0");
    end
    rd(FAULT_STATUS, exp_status(), "clear_status");
    rd(FAULT_COUNT,  32'h0, "clear_count");
    rd(FAULT_CAUSE,  32'h0000_0003, "clear_cause_kept");
    rd(FAULT_ADDR,   32'h2000_0010, "clear_addr_kept");
  endtask

  task automatic test_unknown_and_coincident();
    drive_rec(1'b1, 8'hEE, 32'h3000_0000, 1'b0);
    rd(FAULT_STATUS, 32'h8000_0020, "unknown_status");
    wr(FAULT_STATUS, 32'h7FFF_FFFF);
    wr(FAULT_CAUSE,  32'h8000_0000);
    rd(FAULT_STATUS, 32'h8000_0020, "ignored_writes");
    drive_rec(1'b1, RST_FAULT_IPER, 32'h3000_0040, 1'b1);
    rd(FAULT_STATUS, 32'h8000_0008, "coincident_status");
    rd(FAULT_COUNT,  32'h1, "coincident_count");
    rd(FAULT_CAUSE,  32'h0000_0004, "coincident_cause");
    rd(FAULT_ADDR,   32'h3000_0040, "coincident_addr");
    for (int i = 0; i < HOLD + 5 && sys_rst_req !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    ack_pulse();
  endtask

  task automatic test_saturate();
    drive_rec(1'b1, RST_FAULT_IPER, 32'h3000_0040, 1'b1);
    drive_rec(1'b0, RST_FAULT_IPER, 32'h3000_0040, 1'b0);
    drive_rec(1'b1, RST_FAULT_IPER, 32'h3000_0040, 1'b0);
    rd(FAULT_COUNT, 32'h1, "rearm_count");
    drive_rec(1'b1, RST_FAULT_DPER, 32'h4000_0000, 1'b1);
    for (int i = 1; i < 300; i++)
      drive_rec(1'b1, RST_FAULT_DPER, 32'h4000_0000 + 32'(i * 4), 1'b0);
    rd(FAULT_COUNT,  32'(m_cnt) | REQ_BIT, "sat_count");
    rd(FAULT_STATUS, exp_status(), "sat_status");
    ack_pulse();
  endtask

  task automatic test_misaligned();
    req = 1'b1; we = 1'b0; addr = 4'h6;
    @(posedge clk); #1;
    req = 1'b0;
    total++;
    if (bus_fault !== 1'b1 || rvld !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL misaligned_read: bus_fault=%b rvld=%b rdata=%h required 1 0 0", bus_fault, rvld, rdata);
    end
    @(posedge clk); #1;
    total++;
    if (bus_fault !== 1'b0) begin
      bad++; $display("FAIL bus_fault_pulse: bus_fault=%b required 0", bus_fault);
    end
    wr(4'h2, 32'h8000_0000);
    rd(FAULT_STATUS, exp_status(), "misaligned_write_ignored");
  endtask

  task automatic test_back_to_back();
    rd(FAULT_STATUS, exp_status(), "b2b_status");
    rd(FAULT_CAUSE,  32'h0000_0005, "b2b_cause");
    rd(FAULT_ADDR,   32'h4000_0000, "b2b_addr");
    rd(FAULT_COUNT,  32'h0000_00FF, "b2b_count");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_first_fault();
    test_second_event();
    test_clear_hold();
    test_unknown_and_coincident();
    test_saturate();
    test_misaligned();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
